// File: rtl/aes_round_ctrl_if.sv
// Control bundle between the AES round sequencer and its datapath/owner.
// master = sequencer, slave = datapath and start/abort/stall source.
interface aes_round_ctrl_if #(
    parameter int RW = 4
);
    logic          start;
    logic          abort;
    logic          stall;
    logic          busy;
    logic          done;
    logic          ld_state;
    logic          ld_key;
    logic          sel_init;
    logic          sb_en;
    logic          mc_bypass;
    logic [RW-1:0] round;
    logic [7:0]    rcon;

    modport master (
        input  start, abort, stall,
        output busy, done, ld_state, ld_key, sel_init,
        output sb_en, mc_bypass, round, rcon
    );

    modport slave (
        output start, abort, stall,
        input  busy, done, ld_state, ld_key, sel_init,
        input  sb_en, mc_bypass, round, rcon
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: LOAD, then SUB/UPD per round, then DONE.
// Emits datapath enables, mux selects, round index and rcon.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input logic              clk,
    input logic              reset,
    aes_round_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SUB  = 3'd2,
        S_UPD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [RW-1:0] r_round;
    logic [RW-1:0] w_round_nx;
    logic [7:0]    r_rcon;
    logic [7:0]    w_rcon_nx;
    logic          w_last;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    assign w_last = (r_round == RW'(NR));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_round <= '0;
            r_rcon  <= 8'h01;
        end else begin
            r_state <= w_next;
            r_round <= w_round_nx;
            r_rcon  <= w_rcon_nx;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_round_nx = r_round;
        w_rcon_nx  = r_rcon;
        if (bus.abort) begin
            w_next     = S_IDLE;
            w_round_nx = '0;
            w_rcon_nx  = 8'h01;
        end else if (!bus.stall) begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) w_next = S_LOAD;
                end
                S_LOAD: begin
                    w_next     = S_SUB;
                    w_round_nx = RW'(1);
                    w_rcon_nx  = 8'h01;
                end
                S_SUB: begin
                    w_next = S_UPD;
                end
                S_UPD: begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_SUB;
                        w_round_nx = r_round + RW'(1);
                        w_rcon_nx  = xtime(r_rcon);
                    end
                end
                S_DONE: begin
                    if (bus.start) w_next = S_LOAD;
                end
                default: begin
                    w_next     = S_IDLE;
                    w_round_nx = '0;
                    w_rcon_nx  = 8'h01;
                end
            endcase
        end
    end

    // Stall only masks the write/issue strobes; mode decodes stay state-based.
    assign bus.busy      = (r_state == S_LOAD) || (r_state == S_SUB) ||
                           (r_state == S_UPD);
    assign bus.done      = (r_state == S_DONE);
    assign bus.ld_state  = ((r_state == S_LOAD) || (r_state == S_UPD)) &&
                           !bus.stall;
    assign bus.ld_key    = bus.ld_state;
    assign bus.sel_init  = (r_state == S_LOAD);
    assign bus.sb_en     = (r_state == S_SUB) && !bus.stall;
    assign bus.mc_bypass = (r_state == S_UPD) && w_last;
    assign bus.round     = r_round;
    assign bus.rcon      = r_rcon;
endmodule
